// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Core-wide defaults and typedefs shared by the decoder,
//                the rename register file and the ROB.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int CORE_XLEN  = 32;
    localparam int CORE_NREG  = 32;
    localparam int CORE_TAG_W = 4;
    localparam int CORE_AW    = $clog2(CORE_NREG);

    // ROB tag carried by renamed destinations and commits.
    typedef logic [CORE_TAG_W-1:0] rob_tag_t;

    // Architectural register index.
    typedef logic [CORE_AW-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : rf_read_port
//  Description : One decoder read port: looks up busy/tag/data for a register
//                and forwards a matching same-cycle commit value.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_read_port
    import core_pkg::*;
#(
    parameter int XLEN  = CORE_XLEN,
    parameter int NREG  = CORE_NREG,
    parameter int TAG_W = CORE_TAG_W,
    localparam int AW   = $clog2(NREG)
) (
    input  logic [AW-1:0]                addr,
    input  logic [NREG-1:0]              busy_vec,
    input  logic [NREG-1:0][TAG_W-1:0]   tag_vec,
    input  logic [NREG-1:0][XLEN-1:0]    data_vec,
    input  logic                         cmt_valid,
    input  logic [AW-1:0]                cmt_rd,
    input  logic [TAG_W-1:0]             cmt_tag,
    input  logic [XLEN-1:0]              cmt_data,
    output logic                         ready,
    output logic [XLEN-1:0]              data,
    output logic [TAG_W-1:0]             tag
);

    logic fwd;

    // Lookup on pre-edge state; a commit that retires the pending producer
    // makes the operand ready immediately with the committed value.
    always_comb begin
        data  = data_vec[addr];
        tag   = tag_vec[addr];
        fwd   = busy_vec[addr] && cmt_valid && (cmt_rd == addr) &&
                (cmt_tag == tag_vec[addr]);
        ready = !busy_vec[addr] || fwd;
        if (fwd) begin
            data = cmt_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rename_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : rename_regfile
//  Description : Architectural register file with busy/rename-tag tracking,
//                NUM_READ combinational read ports with commit forwarding,
//                flush recovery and a registered busy count.
//  Revision    : 1.0  initial release
// ============================================================================
module rename_regfile
    import core_pkg::*;
#(
    parameter int XLEN     = CORE_XLEN,
    parameter int NREG     = CORE_NREG,
    parameter int TAG_W    = CORE_TAG_W,
    parameter int NUM_READ = 2,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic [NUM_READ*AW-1:0]       rd_addr,
    output logic [NUM_READ-1:0]          rd_ready,
    output logic [NUM_READ*XLEN-1:0]     rd_data,
    output logic [NUM_READ*TAG_W-1:0]    rd_tag,
    input  logic                         ren_valid,
    input  logic [AW-1:0]                ren_rd,
    input  logic [TAG_W-1:0]             ren_tag,
    input  logic                         cmt_valid,
    input  logic [AW-1:0]                cmt_rd,
    input  logic [TAG_W-1:0]             cmt_tag,
    input  logic [XLEN-1:0]              cmt_data,
    output logic [AW:0]                  busy_cnt
);

    logic [NREG-1:0][XLEN-1:0]  data_r;
    logic [NREG-1:0][TAG_W-1:0] tag_r;
    logic [NREG-1:0]            busy_r;
    logic [NREG-1:0]            busy_nxt;
    logic [AW:0]                cnt_nxt;
    logic                       cmt_wr;
    logic                       ren_wr;

    // Register 0 is hardwired, so writes and renames to it are discarded.
    assign cmt_wr = cmt_valid && (cmt_rd != '0);
    assign ren_wr = ren_valid && (ren_rd != '0);

    // Next busy vector: flush clears all; otherwise a matching commit clears
    // and a rename sets, with the rename winning on the same register.
    always_comb begin
        busy_nxt = busy_r;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (cmt_wr && (tag_r[cmt_rd] == cmt_tag)) begin
                busy_nxt[cmt_rd] = 1'b0;
            end
            if (ren_wr) begin
                busy_nxt[ren_rd] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Popcount of the next-state busy vector, registered as busy_cnt.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
        end
    end

    // State update: commit data always lands (even on flush), renames only
    // outside a flush, and rdy low freezes everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r   <= '0;
            tag_r    <= '0;
            busy_r   <= '0;
            busy_cnt <= '0;
        end else if (rdy) begin
            if (cmt_wr) begin
                data_r[cmt_rd] <= cmt_data;
            end
            if (!flush && ren_wr) begin
                tag_r[ren_rd] <= ren_tag;
            end
            busy_r   <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd_port
        rf_read_port #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .TAG_W (TAG_W)
        ) u_port (
            .addr      (rd_addr[p*AW +: AW]),
            .busy_vec  (busy_r),
            .tag_vec   (tag_r),
            .data_vec  (data_r),
            .cmt_valid (cmt_valid),
            .cmt_rd    (cmt_rd),
            .cmt_tag   (cmt_tag),
            .cmt_data  (cmt_data),
            .ready     (rd_ready[p]),
            .data      (rd_data[p*XLEN +: XLEN]),
            .tag       (rd_tag[p*TAG_W +: TAG_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_rename_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rename_regfile
//  Description : Scoreboard bench for rename_regfile: directed scenarios plus
//                random traffic against a register-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rename_regfile;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 4;
    localparam int NR    = 2;
    localparam int AW    = $clog2(NREG);

    logic                    clk = 1'b0;
    logic                    rst, rdy, flush;
    logic [NR*AW-1:0]        rd_addr;
    logic [NR-1:0]           rd_ready;
    logic [NR*XLEN-1:0]      rd_data;
    logic [NR*TAG_W-1:0]     rd_tag;
    logic                    ren_valid, cmt_valid;
    logic [AW-1:0]           ren_rd, cmt_rd;
    logic [TAG_W-1:0]        ren_tag, cmt_tag;
    logic [XLEN-1:0]         cmt_data;
    logic [AW:0]             busy_cnt;

    // Free-running clock.
    always #5 clk = ~clk;

    rename_regfile #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NUM_READ(NR)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data), .rd_tag(rd_tag),
        .ren_valid(ren_valid), .ren_rd(ren_rd), .ren_tag(ren_tag),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
        .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic [NR-1:0]             ready;
        logic [NR-1:0][XLEN-1:0]   data;
        logic [NR-1:0][TAG_W-1:0]  tag;
        logic [AW:0]               cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: one entry per architectural register.
    logic [XLEN-1:0]  m_data [NREG];
    logic             m_busy [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];

    // Stimulus staged for the next cycle.
    logic             s_rst, s_rdy, s_flush, s_ren_v, s_cmt_v;
    logic [AW-1:0]    s_ren_rd, s_cmt_rd;
    logic [TAG_W-1:0] s_ren_tag, s_cmt_tag;
    logic [XLEN-1:0]  s_cmt_data;
    logic [AW-1:0]    s_addr [NR];

    task automatic idle();
        s_rst = 1'b0; s_rdy = 1'b1; s_flush = 1'b0;
        s_ren_v = 1'b0; s_ren_rd = '0; s_ren_tag = '0;
        s_cmt_v = 1'b0; s_cmt_rd = '0; s_cmt_tag = '0; s_cmt_data = '0;
        for (int p = 0; p < NR; p++) s_addr[p] = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
    endtask

    // Drive one cycle, predict its read results, then advance the model.
    task automatic step();
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        rst = s_rst; rdy = s_rdy; flush = s_flush;
        ren_valid = s_ren_v; ren_rd = s_ren_rd; ren_tag = s_ren_tag;
        cmt_valid = s_cmt_v; cmt_rd = s_cmt_rd; cmt_tag = s_cmt_tag; cmt_data = s_cmt_data;
        for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = s_addr[p];
        for (int p = 0; p < NR; p++) begin
            logic [AW-1:0] a;
            a = s_addr[p];
            e.tag[p] = m_tag[a];
            if (!m_busy[a]) begin
                e.ready[p] = 1'b1; e.data[p] = m_data[a];
            end else if (s_cmt_v && s_cmt_rd == a && s_cmt_tag == m_tag[a]) begin
                e.ready[p] = 1'b1; e.data[p] = s_cmt_data;
            end else begin
                e.ready[p] = 1'b0; e.data[p] = m_data[a];
            end
        end
        n = 0;
        for (int r = 0; r < NREG; r++) if (m_busy[r]) n++;
        e.cnt = (AW+1)'(n);
        exp_q.push_back(e);
        if (s_rst) begin
            model_reset();
        end else if (s_rdy) begin
            if (s_cmt_v && s_cmt_rd != 0) m_data[s_cmt_rd] = s_cmt_data;
            if (s_flush) begin
                for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
            end else begin
                if (s_cmt_v && s_cmt_rd != 0 && m_tag[s_cmt_rd] == s_cmt_tag &&
                    !(s_ren_v && s_ren_rd == s_cmt_rd))
                    m_busy[s_cmt_rd] = 1'b0;
                if (s_ren_v && s_ren_rd != 0) begin
                    m_busy[s_ren_rd] = 1'b1; m_tag[s_ren_rd] = s_ren_tag;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s port%0d t=%0t actual=0x%08h required=0x%08h", name, p, $time, act, req);
        end
    endtask

    // Monitor: pop one expectation per cycle and compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                for (int p = 0; p < NR; p++) begin
                    chk("rd_ready", p, 32'(rd_ready[p]), 32'(e.ready[p]));
                    chk("rd_data", p, rd_data[p*XLEN +: XLEN], e.data[p]);
                    if (!e.ready[p]) chk("rd_tag", p, 32'(rd_tag[p*TAG_W +: TAG_W]), 32'(e.tag[p]));
                end
                chk("busy_cnt", 0, 32'(busy_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        int t;
        model_reset();
        idle();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        ren_valid = 1'b0; ren_rd = '0; ren_tag = '0;
        cmt_valid = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);

        // Reset state on x5 and x0.
        idle(); s_addr[0] = 5; s_addr[1] = 0; step();
        // Rename x5 tag 3; same-cycle read unaffected, next cycle pending.
        idle(); s_ren_v = 1; s_ren_rd = 5; s_ren_tag = 3; s_addr[0] = 5; step();
        idle(); s_addr[0] = 5; s_addr[1] = 5; step();
        // Commit with forwarding, then settled value.
        idle(); s_cmt_v = 1; s_cmt_rd = 5; s_cmt_tag = 3; s_cmt_data = 32'hDEADBEEF;
        s_addr[0] = 5; step();
        idle(); s_addr[0] = 5; step();
        // Stale commit writes data but leaves the newer rename pending.
        idle(); s_ren_v = 1; s_ren_rd = 5; s_ren_tag = 3; step();
        idle(); s_ren_v = 1; s_ren_rd = 5; s_ren_tag = 7; step();
        idle(); s_cmt_v = 1; s_cmt_rd = 5; s_cmt_tag = 3; s_cmt_data = 32'h11; s_addr[0] = 5; step();
        idle(); s_addr[0] = 5; step();
        // Matching commit plus rename on the same register: rename wins.
        idle(); s_cmt_v = 1; s_cmt_rd = 5; s_cmt_tag = 7; s_cmt_data = 32'h77;
        s_ren_v = 1; s_ren_rd = 5; s_ren_tag = 9; s_addr[0] = 5; step();
        idle(); s_addr[0] = 5; step();
        // Flush with concurrent commit and dropped rename.
        idle(); s_ren_v = 1; s_ren_rd = 1; s_ren_tag = 1; step();
        idle(); s_ren_v = 1; s_ren_rd = 2; s_ren_tag = 2; step();
        idle(); s_ren_v = 1; s_ren_rd = 3; s_ren_tag = 4; s_addr[0] = 1; s_addr[1] = 2; step();
        idle(); s_flush = 1; s_cmt_v = 1; s_cmt_rd = 2; s_cmt_tag = 6; s_cmt_data = 32'h22;
        s_ren_v = 1; s_ren_rd = 4; s_ren_tag = 5; s_addr[0] = 3; s_addr[1] = 5; step();
        idle(); s_addr[0] = 2; s_addr[1] = 4; step();
        idle(); s_addr[0] = 1; s_addr[1] = 3; step();
        // rdy low freezes rename, commit and flush.
        idle(); s_ren_v = 1; s_ren_rd = 6; s_ren_tag = 1; step();
        idle(); s_rdy = 0; s_flush = 1; s_ren_v = 1; s_ren_rd = 7; s_ren_tag = 2;
        s_cmt_v = 1; s_cmt_rd = 6; s_cmt_tag = 1; s_cmt_data = 32'h99; s_addr[0] = 6; step();
        idle(); s_addr[0] = 6; s_addr[1] = 7; step();
        // Register 0 stays zero and ready.
        idle(); s_ren_v = 1; s_ren_rd = 0; s_ren_tag = 4;
        s_cmt_v = 1; s_cmt_rd = 0; s_cmt_tag = 4; s_cmt_data = 32'h55; step();
        idle(); s_addr[0] = 0; s_addr[1] = 6; step();

        // Random traffic over a small register window to force collisions.
        for (int i = 0; i < 2000; i++) begin
            idle();
            s_rst   = (i == 1000);
            s_rdy   = ($urandom_range(0, 9) != 0);
            s_flush = ($urandom_range(0, 29) == 0);
            s_ren_v = $urandom_range(0, 1) == 1;
            s_ren_rd = AW'($urandom_range(0, 7));
            s_ren_tag = TAG_W'($urandom);
            s_cmt_v = $urandom_range(0, 1) == 1;
            s_cmt_rd = AW'($urandom_range(0, 7));
            s_cmt_tag = ($urandom_range(0, 3) != 0) ? m_tag[s_cmt_rd] : TAG_W'($urandom);
            s_cmt_data = $urandom;
            for (int p = 0; p < NR; p++)
                s_addr[p] = ($urandom_range(0, 1) == 1) ? s_cmt_rd : AW'($urandom_range(0, 7));
            step();
        end

        idle(); step();
        t = 0;
        while (exp_q.size() != 0 && t < 10) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
